// File: rtl/nco_tune_controller.sv
// nco_tune_controller
// Grants retune requests to the DDC NCO in round-robin order. Each granted
// frequency word is applied either as a phase-continuous linear glide or as
// a hard load with phase clear. The request is acked once the NCO has produced
// SETTLE_CYCLES valid samples at the new frequency.
module nco_tune_controller #(
    parameter int NUM_REQ       = 4,
    parameter int RAMP_SHIFT    = 3,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [32*NUM_REQ-1:0]      req_freq_word,
    input  logic [NUM_REQ-1:0]         req_phase_reset,
    output logic [NUM_REQ-1:0]         ack,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic [31:0]                nco_frequency_word,
    output logic                       nco_enable,
    output logic                       nco_phase_clear,
    input  logic                       nco_valid
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int CNT_W = (SET_W > RAMP_SHIFT + 1) ? SET_W : RAMP_SHIFT + 1;
    localparam logic [CNT_W-1:0] RAMP_LAST  = CNT_W'((1 << RAMP_SHIFT) - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_RAMP, S_SETTLE, S_ACK} state_t;

    state_t            state_reg, state_next;
    logic [ID_W-1:0]   ptr_reg, ptr_next;
    logic [ID_W-1:0]   grant_next;
    logic [31:0]       target_reg, target_next;
    logic [31:0]       step_reg, step_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [31:0]       word_next;
    logic [NUM_REQ-1:0] ack_next;
    logic              busy_next;
    logic              clear_next;

    logic [31:0]       word_arr [NUM_REQ];
    logic [ID_W:0]     base;
    logic [2*NUM_REQ-1:0] rot;
    logic [ID_W-1:0]   pick;
    logic              found;
    logic              hard_load;
    logic [31:0]       delta;

    // Unpack the flat request word bus into one word per requester.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word
        assign word_arr[gi] = req_freq_word[32*gi +: 32];
    end

    // Round-robin pick: rotate the request vector so the slot after the
    // pointer sits at bit 0, then take the lowest set bit.
    always_comb begin
        logic [ID_W:0] s;
        s     = '0;
        base  = {1'b0, ptr_reg} + (ID_W+1)'(1);
        rot   = {req, req} >> base;
        pick  = '0;
        found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                s = base + (ID_W+1)'(k);
                if (int'(s) >= NUM_REQ) begin
                    s = s - (ID_W+1)'(NUM_REQ);
                end
                pick  = s[ID_W-1:0];
                found = 1'b1;
            end
        end
        hard_load = req_phase_reset[pick] || (RAMP_SHIFT == 0);
        delta     = word_arr[pick] - nco_frequency_word;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (found) state_next = hard_load ? S_SETTLE : S_RAMP;
            S_RAMP:   if (cnt_reg == '0) state_next = S_SETTLE;
            S_SETTLE: if (nco_valid && cnt_reg == CNT_W'(1)) state_next = S_ACK;
            default:  state_next = S_IDLE;
        endcase
    end

    // Next values for the registered outputs and datapath.
    always_comb begin
        ptr_next    = ptr_reg;
        grant_next  = grant_id;
        target_next = target_reg;
        step_next   = step_reg;
        cnt_next    = cnt_reg;
        word_next   = nco_frequency_word;
        busy_next   = busy;
        ack_next    = '0;
        clear_next  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (found) begin
                    ptr_next    = pick;
                    grant_next  = pick;
                    target_next = word_arr[pick];
                    // Signed delta takes the shortest path around the wrap.
                    step_next   = $signed(delta) >>> RAMP_SHIFT;
                    busy_next   = 1'b1;
                    if (hard_load) begin
                        word_next  = word_arr[pick];
                        clear_next = req_phase_reset[pick];
                        cnt_next   = SETTLE_LD;
                    end else begin
                        cnt_next   = RAMP_LAST;
                    end
                end
            end
            S_RAMP: begin
                if (cnt_reg != '0) begin
                    word_next = nco_frequency_word + step_reg;
                    cnt_next  = cnt_reg - CNT_W'(1);
                end else begin
                    // Final step lands exactly on target, dropping the shift residue.
                    word_next = target_reg;
                    cnt_next  = SETTLE_LD;
                end
            end
            S_SETTLE: begin
                if (nco_valid) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) begin
                        ack_next = NUM_REQ'(1) << grant_id;
                    end
                end
            end
            default: begin
                busy_next = 1'b0;
            end
        endcase
    end

    // Output and datapath registers; the NCO enable simply follows run.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg            <= ID_W'(NUM_REQ - 1);
            grant_id           <= '0;
            target_reg         <= '0;
            step_reg           <= '0;
            cnt_reg            <= '0;
            nco_frequency_word <= '0;
            busy               <= 1'b0;
            ack                <= '0;
            nco_phase_clear    <= 1'b0;
            nco_enable         <= 1'b0;
        end else begin
            ptr_reg            <= ptr_next;
            grant_id           <= grant_next;
            target_reg         <= target_next;
            step_reg           <= step_next;
            cnt_reg            <= cnt_next;
            nco_frequency_word <= word_next;
            busy               <= busy_next;
            ack                <= ack_next;
            nco_phase_clear    <= clear_next;
            nco_enable         <= run;
        end
    end

endmodule

// File: tb/tb_nco_tune_controller.sv
// Directed testbench for nco_tune_controller: glides, wrap glide, hard load,
// round-robin arbitration, settle stall and reset mid-ramp.
`timescale 1ns/1ps
module tb_nco_tune_controller;

    logic         clk = 1'b0;
    logic         rst;
    logic         run;
    logic [3:0]   req;
    logic [127:0] req_freq_word;
    logic [3:0]   req_phase_reset;
    logic [3:0]   ack;
    logic         busy;
    logic [1:0]   grant_id;
    logic [31:0]  nco_frequency_word;
    logic         nco_enable;
    logic         nco_phase_clear;
    logic         nco_valid;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] g_up   [8];
    logic [31:0] g_wrap [8];

    nco_tune_controller #(
        .NUM_REQ(4), .RAMP_SHIFT(3), .SETTLE_CYCLES(16)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .run                (run),
        .req                (req),
        .req_freq_word      (req_freq_word),
        .req_phase_reset    (req_phase_reset),
        .ack                (ack),
        .busy               (busy),
        .grant_id           (grant_id),
        .nco_frequency_word (nco_frequency_word),
        .nco_enable         (nco_enable),
        .nco_phase_clear    (nco_phase_clear),
        .nco_valid          (nco_valid)
    );

    // NCO model: a valid sample every cycle it is enabled.
    assign nco_valid = nco_enable;

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Step through a glide and compare each NCO word with the table.
    task automatic check_glide(input logic [31:0] exp [8]);
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("glide_word%0d", k), nco_frequency_word, exp[k]);
        end
    endtask

    // Wait (bounded) for the ack, check its timing and the following busy drop.
    task automatic settle_and_ack(input logic [3:0] exp_ack, input int exp_cycles,
                                  input logic [31:0] exp_word, input bit drop);
        int n = 0;
        int clr_seen = 0;
        while (ack == 4'b0 && n < 300) begin
            tick();
            n++;
            if (nco_phase_clear) clr_seen++;
        end
        check("settle_cycles", n, exp_cycles);
        check("ack_pulse", {28'b0, ack}, {28'b0, exp_ack});
        check("busy_in_ack", {31'b0, busy}, 32'd1);
        check("word_held", nco_frequency_word, exp_word);
        check("no_clear_in_settle", clr_seen, 0);
        if (drop) req = req & ~exp_ack;
        tick();
        check("ack_one_cycle", {28'b0, ack}, 32'd0);
        check("busy_after_ack", {31'b0, busy}, 32'd0);
        $display("txn: ack=%b word=0x%08h after %0d cycles", exp_ack, exp_word, n);
    endtask

    task automatic set_req(input int id, input logic [31:0] word, input logic pr);
        req_freq_word[32*id +: 32] = word;
        req_phase_reset[id]        = pr;
        req[id]                    = 1'b1;
    endtask

    task automatic grant_tick(input int id, input logic [31:0] exp_word, input logic exp_clr);
        tick();
        check("grant_id", {30'b0, grant_id}, id);
        check("busy_on_grant", {31'b0, busy}, 32'd1);
        check("grant_word", nco_frequency_word, exp_word);
        check("phase_clear", {31'b0, nco_phase_clear}, {31'b0, exp_clr});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        g_up   = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h500, 32'h600, 32'h700, 32'h800};
        g_wrap = '{32'hC0, 32'h80, 32'h40, 32'h0,
                   32'hFFFF_FFC0, 32'hFFFF_FF80, 32'hFFFF_FF40, 32'hFFFF_FF00};
        rst = 1'b1; run = 1'b0; req = '0; req_freq_word = '0; req_phase_reset = '0;
        tick();
        tick();
        check("rst_ack", {28'b0, ack}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_grant", {30'b0, grant_id}, 32'd0);
        check("rst_word", nco_frequency_word, 32'd0);
        check("rst_enable", {31'b0, nco_enable}, 32'd0);
        check("rst_clear", {31'b0, nco_phase_clear}, 32'd0);
        rst = 1'b0;

        // 1: glide up 0 -> 0x800
        run = 1'b1;
        set_req(0, 32'h0000_0800, 1'b0);
        grant_tick(0, 32'h0, 1'b0);
        check("enable_follows_run", {31'b0, nco_enable}, 32'd1);
        check_glide(g_up);
        settle_and_ack(4'b0001, 16, 32'h800, 1'b1);

        // Hard load to 0x100 from requester 3 (pointer at 0, only 3 pending)
        set_req(3, 32'h0000_0100, 1'b1);
        grant_tick(3, 32'h100, 1'b1);
        settle_and_ack(4'b1000, 16, 32'h100, 1'b1);

        // 2: wrap glide 0x100 -> 0xFFFF_FF00 along the short path
        set_req(1, 32'hFFFF_FF00, 1'b0);
        grant_tick(1, 32'h100, 1'b0);
        check_glide(g_wrap);
        settle_and_ack(4'b0010, 16, 32'hFFFF_FF00, 1'b1);

        // 3: hard retune with phase clear
        set_req(2, 32'h1234_5678, 1'b1);
        grant_tick(2, 32'h1234_5678, 1'b1);
        settle_and_ack(4'b0100, 16, 32'h1234_5678, 1'b1);

        // 4: arbitration with held requests
        do_reset();
        req_freq_word   = {32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
        req_phase_reset = 4'b1111;
        req             = 4'b0101;
        grant_tick(0, 32'h1000, 1'b1);
        settle_and_ack(4'b0001, 16, 32'h1000, 1'b0);
        grant_tick(2, 32'h3000, 1'b1);
        req = 4'b1111;
        settle_and_ack(4'b0100, 16, 32'h3000, 1'b0);
        grant_tick(3, 32'h4000, 1'b1);
        settle_and_ack(4'b1000, 16, 32'h4000, 1'b0);
        grant_tick(0, 32'h1000, 1'b1);
        settle_and_ack(4'b0001, 16, 32'h1000, 1'b0);
        grant_tick(1, 32'h2000, 1'b1);
        settle_and_ack(4'b0010, 16, 32'h2000, 1'b0);
        grant_tick(2, 32'h3000, 1'b1);
        req = 4'b0000;
        settle_and_ack(4'b0100, 16, 32'h3000, 1'b0);

        // 5: settle stall with run low
        set_req(0, 32'hABCD_0000, 1'b1);
        grant_tick(0, 32'hABCD_0000, 1'b1);
        for (int k = 0; k < 5; k++) tick();
        run = 1'b0;
        begin
            int stray_ack = 0;
            int busy_low  = 0;
            int en_high   = 0;
            for (int k = 0; k < 50; k++) begin
                tick();
                if (ack != 4'b0) stray_ack++;
                if (!busy) busy_low++;
                if (nco_enable) en_high++;
            end
            check("stall_no_ack", stray_ack, 0);
            check("stall_busy", busy_low, 0);
            check("stall_enable_low", en_high, 0);
        end
        run = 1'b1;
        settle_and_ack(4'b0001, 11, 32'hABCD_0000, 1'b1);

        // 6: reset on the third ramp cycle, then regrant of the held request
        do_reset();
        set_req(0, 32'h0000_0800, 1'b0);
        grant_tick(0, 32'h0, 1'b0);
        tick();
        check("ramp_c2", nco_frequency_word, 32'h100);
        tick();
        check("ramp_c3", nco_frequency_word, 32'h200);
        rst = 1'b1;
        tick();
        check("midrst_word", nco_frequency_word, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_ack", {28'b0, ack}, 32'd0);
        check("midrst_enable", {31'b0, nco_enable}, 32'd0);
        check("midrst_grant", {30'b0, grant_id}, 32'd0);
        rst = 1'b0;
        grant_tick(0, 32'h0, 1'b0);
        check_glide(g_up);
        settle_and_ack(4'b0001, 16, 32'h800, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nco_tune_controller.md
Name: nco_tune_controller

Overview:
Schedules retune requests for the DDC's NCO. Round-robin arbitration among NUM_REQ requesters, each supplying a 32-bit frequency word. The granted word reaches the NCO either as a phase-continuous linear glide or as a hard load with phase clear. Each request is acked only after the NCO has produced SETTLE_CYCLES valid samples at the new frequency.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
RAMP_SHIFT, 3, glide length = 2^RAMP_SHIFT cycles (0 = immediate load)
SETTLE_CYCLES, 16, NCO valid samples to wait before ack (>=1)

Ports:
clk  in  1  processing clock
rst  in  1  reset, synchronous, active-high
run  in  1  global NCO run request
req  in  NUM_REQ  per-requester retune request, held until ack
req_freq_word  in  32*NUM_REQ  flat target words; requester i at [32*i+31:32*i]
req_phase_reset  in  NUM_REQ  1 = hard load plus phase clear, 0 = glide
ack  out  NUM_REQ  one-cycle completion pulse to the granted requester
busy  out  1  high from grant through the ack cycle
grant_id  out  $clog2(NUM_REQ)  index of current/last granted requester
nco_frequency_word  out  32  word driven to NCO frequency_word
nco_enable  out  1  drives NCO enable
nco_phase_clear  out  1  one-cycle pulse; NCO clears its phase accumulator
nco_valid  in  1  NCO valid_out

Behaviour:
- One clock; reset synchronous active-high.
- All outputs registered. Reset values: ack=0, busy=0, grant_id=0, nco_frequency_word=0, nco_enable=0, nco_phase_clear=0, state=IDLE, RR pointer=NUM_REQ-1 (so requester 0 wins first).
- nco_enable <= run every cycle, independent of state.
- States: IDLE, RAMP, SETTLE, ACK.
- IDLE, any req high:
  - Pick the first set bit searching from pointer+1, wrapping. Set pointer and grant_id to it.
  - Latch target. Compute delta = target - nco_frequency_word (32-bit wrap, read as signed = shortest path).
  - step = delta >>> RAMP_SHIFT (arithmetic). Set busy=1.
  - If req_phase_reset[g]=1 or RAMP_SHIFT=0: load the word immediately. Pulse nco_phase_clear=1 only when the phase-reset flag is set. Go to SETTLE.
  - Otherwise go to RAMP with step counter = 2^RAMP_SHIFT-1.
- RAMP, one update per cycle:
  - Counter >0: nco_frequency_word += step (mod 2^32); counter decrements.
  - Counter =0: nco_frequency_word = target exactly, removing truncation residue. Go to SETTLE.
  - Total glide is 2^RAMP_SHIFT cycles.
- SETTLE:
  - Counter loads SETTLE_CYCLES on entry and decrements only on cycles with nco_valid=1.
  - Reaching 0 goes to ACK.
  - run=0 stalls settle indefinitely, since valid stays low. This is required behaviour, with no timeout.
- ACK:
  - ack[grant_id]=1 for exactly one cycle; busy=0 on the next cycle.
  - Return to IDLE. Arbitration resumes on the cycle after ACK.
- Requester contract:
  - Hold req and word stable until ack.
  - Drop req in the cycle after ack.
  - A req still high in the IDLE cycle after ack is treated as a new request, but round-robin order still applies.
- Requests arriving while busy are ignored until IDLE. req or word changes by the granted requester after grant have no effect.
- Simultaneous requests: at most one grant per IDLE cycle. Losers stay pending.
- rst mid-operation (any state):
  - Next edge forces reset values, and no ack is issued for the aborted request.
  - nco_frequency_word returns to 0; still-high requests re-arbitrate from pointer NUM_REQ-1.
- nco_phase_clear is never high except in the single cycle after a phase-reset grant.

Test Plan:
1. Glide up: reset; run=1; req[0]=1, word 0x0000_0800, phase_reset=0 -> nco_frequency_word steps 0x100, 0x200 … 0x700, then 0x800 over 8 consecutive cycles. After 16 valid cycles, ack[0] pulses once; busy drops.
2. Wrap glide: start word 0x0000_0100; req[1] to 0xFFFF_FF00 -> step −0x40; words 0xC0, 0x80, 0x40, 0x0, 0xFFFF_FFC0, 0xFFFF_FF80, 0xFFFF_FF40, final 0xFFFF_FF00. Never glides via +2^31.
3. Hard retune: req[2]=1, word 0x1234_5678, phase_reset=1 -> word loaded on the cycle after grant, nco_phase_clear high exactly 1 cycle, no intermediate words, ack[2] after 16 valid cycles.
4. Arbitration: after reset, req=4'b0101 held -> grants 0 then 2. Then req=4'b1111 held -> grants 3, 0, 1, 2 in order, each with a single ack pulse; never two acks at once.
5. Settle stall: run=0 during SETTLE for 50 cycles -> no ack, busy stays 1, nco_enable=0. Restore run=1 -> ack after the remaining valid count.
6. Reset mid-ramp: assert rst on the 3rd RAMP cycle -> next edge all outputs 0, no ack. After release, the still-high req[0] is regranted and completes normally.
